// File: rtl/pipe_hold_ctrl.sv
// Front-end pipeline registers (PC, F/D, D/E) with hazard stall, bubble injection,
// delayed-branch redirect and saturating stall performance counters.
module pipe_hold_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        npc_sel,
  input  logic [31:0] npc,
  input  logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic        D_valid,
  output logic [31:0] E_Instr,
  output logic [31:0] E_PC,
  output logic        E_valid,
  output logic [31:0] stall_cnt,
  output logic [7:0]  max_run
);

  logic [7:0]  run_len;
  logic [7:0]  run_len_nxt;
  logic [7:0]  max_run_nxt;
  logic [31:0] pc_nxt;

  always_comb begin
    run_len_nxt = '0;
    if (stall) begin
      run_len_nxt = (run_len == 8'hFF) ? 8'hFF : run_len + 8'd1;
    end
    max_run_nxt = (run_len_nxt > max_run) ? run_len_nxt : max_run;
  end

  // A redirect raised during a stall is dropped; the branch stays in D and re-asserts.
  always_comb begin
    pc_nxt = F_PC;
    if (!stall) begin
      pc_nxt = npc_sel ? {npc[31:2], 2'b00} : F_PC + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      F_PC      <= RESET_PC;
      D_Instr   <= NOP_INSTR;
      D_PC      <= '0;
      D_valid   <= 1'b0;
      E_Instr   <= NOP_INSTR;
      E_PC      <= '0;
      E_valid   <= 1'b0;
      stall_cnt <= '0;
      run_len   <= '0;
      max_run   <= '0;
    end else begin
      F_PC    <= pc_nxt;
      run_len <= run_len_nxt;
      max_run <= max_run_nxt;
      if (stall) begin
        E_Instr <= NOP_INSTR;
        E_PC    <= D_PC;
        E_valid <= 1'b0;
        if (stall_cnt != 32'hFFFF_FFFF) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
      end else begin
        D_Instr <= F_Instr;
        D_PC    <= F_PC;
        D_valid <= 1'b1;
        E_Instr <= D_Instr;
        E_PC    <= D_PC;
        E_valid <= D_valid;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl with hand-computed expectations.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        npc_sel;
  logic [31:0] npc;
  logic [31:0] F_Instr;
  logic [31:0] F_PC, D_Instr, D_PC, E_Instr, E_PC, stall_cnt;
  logic        D_valid, E_valid;
  logic [7:0]  max_run;

  logic        im_ovr;
  logic [31:0] im_word;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] ADD_W = 32'h0109_5020;
  localparam logic [31:0] LW_W  = 32'h8D09_0004;

  // IM model: tag each word with its address unless a specific word is forced.
  assign F_Instr = im_ovr ? im_word : {8'hA5, F_PC[23:0]};

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.RESET_PC(32'h0000_3000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .npc_sel(npc_sel), .npc(npc),
    .F_Instr(F_Instr), .F_PC(F_PC), .D_Instr(D_Instr), .D_PC(D_PC), .D_valid(D_valid),
    .E_Instr(E_Instr), .E_PC(E_PC), .E_valid(E_valid), .stall_cnt(stall_cnt),
    .max_run(max_run)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_fpc"}, F_PC, 32'h3000);
    chk({tag, "_dinstr"}, D_Instr, 32'h0);
    chk({tag, "_dpc"}, D_PC, 32'h0);
    chk({tag, "_dvalid"}, {31'b0, D_valid}, 32'h0);
    chk({tag, "_einstr"}, E_Instr, 32'h0);
    chk({tag, "_epc"}, E_PC, 32'h0);
    chk({tag, "_evalid"}, {31'b0, E_valid}, 32'h0);
    chk({tag, "_scnt"}, stall_cnt, 32'h0);
    chk({tag, "_maxrun"}, {24'b0, max_run}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; npc_sel = 1'b0; npc = '0;
    im_ovr = 1'b0; im_word = '0;
    #21;
    chk_reset_vals("rst");
    reset_n = 1'b1;

    // free running from reset
    step();
    chk("e1_fpc", F_PC, 32'h3004);
    chk("e1_dpc", D_PC, 32'h3000);
    chk("e1_dinstr", D_Instr, 32'hA500_3000);
    chk("e1_dvalid", {31'b0, D_valid}, 32'h1);
    chk("e1_evalid", {31'b0, E_valid}, 32'h0);
    step();
    chk("e2_fpc", F_PC, 32'h3008);
    chk("e2_dpc", D_PC, 32'h3004);
    chk("e2_epc", E_PC, 32'h3000);
    chk("e2_evalid", {31'b0, E_valid}, 32'h1);
    step();
    chk("e3_fpc", F_PC, 32'h300C);
    chk("e3_einstr", E_Instr, 32'hA500_3004);
    step();
    chk("e4_fpc", F_PC, 32'h3010);

    // redirect with delay slot kept
    npc_sel = 1'b1; npc = 32'h0000_3043;
    step();
    npc_sel = 1'b0;
    chk("br_fpc", F_PC, 32'h3040);
    chk("br_dpc", D_PC, 32'h3010);
    chk("br_dinstr", D_Instr, 32'hA500_3010);

    // build D=lw, E=add, then stall two edges
    im_ovr = 1'b1; im_word = ADD_W;
    step();
    im_word = LW_W;
    step();
    im_ovr = 1'b0;
    chk("pre_dinstr", D_Instr, LW_W);
    chk("pre_einstr", E_Instr, ADD_W);
    stall = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step();
      chk("st_fpc", F_PC, 32'h3048);
      chk("st_dinstr", D_Instr, LW_W);
      chk("st_einstr", E_Instr, 32'h0);
      chk("st_evalid", {31'b0, E_valid}, 32'h0);
      chk("st_epc", E_PC, 32'h3044);
      chk("st_scnt", stall_cnt, i);
    end
    stall = 1'b0;
    step();
    chk("rel_einstr", E_Instr, LW_W);
    chk("rel_evalid", {31'b0, E_valid}, 32'h1);
    chk("rel_fpc", F_PC, 32'h304C);
    chk("rel_scnt", stall_cnt, 32'd2);
    chk("rel_maxrun", {24'b0, max_run}, 32'd2);

    // stall and npc_sel together: redirect ignored, then taken
    stall = 1'b1; npc_sel = 1'b1; npc = 32'h0000_5000;
    step();
    chk("both_fpc", F_PC, 32'h304C);
    chk("both_scnt", stall_cnt, 32'd3);
    stall = 1'b0;
    step();
    npc_sel = 1'b0;
    chk("late_fpc", F_PC, 32'h5000);
    chk("late_dpc", D_PC, 32'h304C);

    // stall glitch between edges is invisible
    stall = 1'b1; #2; stall = 1'b0;
    step();
    chk("glitch_scnt", stall_cnt, 32'd3);
    chk("glitch_fpc", F_PC, 32'h5004);

    // asynchronous reset mid-stall
    stall = 1'b1;
    step();
    step();
    chk("mid_scnt", stall_cnt, 32'd5);
    #2; reset_n = 1'b0; #1;
    chk_reset_vals("arst");
    reset_n = 1'b1;

    // long stall run saturates max_run
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) chk("run254", {24'b0, max_run}, 32'd254);
      if (i == 255) chk("run255", {24'b0, max_run}, 32'd255);
    end
    chk("long_maxrun", {24'b0, max_run}, 32'hFF);
    chk("long_scnt", stall_cnt, 32'd300);
    chk("long_fpc", F_PC, 32'h3000);
    chk("long_dvalid", {31'b0, D_valid}, 32'h0);
    stall = 1'b0;
    step();
    chk("long_runlen", {24'b0, dut.run_len}, 32'h0);
    chk("long_rel_maxrun", {24'b0, max_run}, 32'hFF);
    chk("long_rel_fpc", F_PC, 32'h3004);
    chk("long_rel_dpc", D_PC, 32'h3000);

    // PC wrap at top of address space
    npc_sel = 1'b1; npc = 32'hFFFF_FFFF;
    step();
    npc_sel = 1'b0;
    chk("wrap_top", F_PC, 32'hFFFF_FFFC);
    step();
    chk("wrap_zero", F_PC, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Front-end pipeline register block for the five-stage MIPS core. It owns the PC, the F/D register and the D/E register. It acts on the combinational `stall` request from the hazard detector: it freezes PC and F/D and injects a NOP bubble into D/E. It also applies delayed-branch redirects from the D stage and keeps stall performance counters readable by the debug/trace logic.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `NOP_INSTR`, 32'h0000_0000, instruction word injected as a bubble.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `stall` input 1: hazard stall request for the current cycle (combinational, from the hazard detector).
- `npc_sel` input 1: D-stage branch/jump taken this cycle.
- `npc` input 32: redirect target; bits [1:0] are ignored and forced to 0.
- `F_Instr` input 32: instruction fetched at `F_PC` (combinational IM read).
- `F_PC` output 32: current fetch PC.
- `D_Instr`, `D_PC` output 32 each: F/D register contents.
- `D_valid` output 1: F/D holds a real fetched instruction.
- `E_Instr`, `E_PC` output 32 each: D/E register contents.
- `E_valid` output 1: D/E holds a real instruction, not a bubble.
- `stall_cnt` output 32: total stall cycles since reset, saturating.
- `max_run` output 8: longest run of consecutive stall cycles, saturating.

## Operation
- Reset values, applied immediately and asynchronously:
  - `F_PC` = RESET_PC.
  - `D_Instr` = `E_Instr` = NOP_INSTR.
  - `D_PC` = `E_PC` = 0.
  - `D_valid` = `E_valid` = 0.
  - `stall_cnt` = 0, `max_run` = 0, internal `run_len` = 0.
- PC update, in priority order:
  - `stall`=1: hold.
  - else `npc_sel`=1: load {npc[31:2],2'b00}.
  - else: `F_PC`+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- F/D update:
  - `stall`=1: hold all fields.
  - else: load `F_Instr`, `F_PC`, and set `D_valid`=1.
- D/E update:
  - `stall`=1: load `E_Instr`=NOP_INSTR, `E_PC`=`D_PC`, `E_valid`=0. This is a bubble; `E_PC` is kept for trace only.
  - else: load `D_Instr`, `D_PC`, and set `E_valid`=`D_valid`.
- Delayed branch: the delay slot is never flushed. `npc_sel` only changes the next PC. The instruction already in F enters F/D normally.
- `stall` and `npc_sel` high together: `npc_sel` is ignored. The branch is still held in D and re-asserts `npc_sel` on the cycle `stall` drops.
- Stall counters:
  - `stall_cnt` increments by 1 on each edge with `stall`=1 and holds at 32'hFFFF_FFFF.
  - `run_len` counts consecutive stall edges and holds at 8'hFF. It clears to 0 on an edge with `stall`=0.
  - On every edge, `max_run` <= max(`max_run`, next `run_len`), so `max_run` updates during the run, not at its end.
- No combinational path from any input to any output. All outputs are registered.

## Timing
- Latency:
  - `F_Instr` to `D_Instr`: 1 edge.
  - `D_Instr` to `E_Instr`: 1 edge.
  - `npc_sel` to `F_PC`: 1 edge.
- N consecutive stall cycles:
  - PC and F/D are frozen for exactly N edges.
  - D/E receives exactly N bubbles.
  - The held D instruction enters E on the first edge after `stall` falls.
- After reset deassertion:
  - Edge 1: `D_valid`=1 with the `RESET_PC` instruction.
  - Edge 2: `E_valid`=1.
- `reset_n` asserted mid-stall or mid-redirect: every register returns to its reset value at once. Pending redirects and run lengths are discarded.
- `stall` is sampled only at the rising edge. Glitches between edges have no effect.

## Test plan
- Reset, then 3 free-running edges with IM returning PC-tagged words. Required:
  - `F_PC` = 3000, 3004, 3008, 300C.
  - `D_PC` trails `F_PC` by one edge.
  - `E_valid` goes 0 → 0 → 1.
- `stall` high for 2 edges with D=`lw`, E=`add`. Required:
  - `F_PC` and `D_Instr` are unchanged for 2 edges.
  - `E_Instr`=0 and `E_valid`=0 for 2 edges.
  - Then E=`lw`.
  - `stall_cnt`=2, `max_run`=2.
- `npc_sel`=1, `npc`=32'h0000_3043 with `stall`=0 at `F_PC`=3010. Required:
  - Next `F_PC`=3040.
  - `D_PC`=3010 (delay slot kept).
- `npc_sel` and `stall` both high for 1 edge, then `npc_sel` only. Required:
  - The first edge leaves `F_PC` unchanged.
  - The second edge loads the target.
- `reset_n` pulsed low between edges during a 3-cycle stall. Required:
  - All outputs take reset values before the next edge.
  - `stall_cnt`=0.
- 300 consecutive stall edges, then release. Required:
  - `max_run`=8'hFF.
  - `stall_cnt`=300.
  - `run_len` clears on release.
